// File: rtl/usrt_pkg.sv
// usrt_pkg: shared definitions for the USRT receive controller.
// Register map (word index = i_Paddr[3:2]), CTRL/STATUS bit positions,
// receive-controller state encodings and the idle-timeout multiplier.
package usrt_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_BAUD   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_DATA   = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE_RXNE = 1;
   localparam int CTRL_IE_OVR  = 2;
   localparam int CTRL_IE_TO   = 3;
   localparam int CTRL_FLUSH   = 4;

   localparam int ST_RXNE      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVR       = 2;
   localparam int ST_TO        = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_LEVEL_W   = 5;

   // Four 10-bit character times expressed in baud-divisor units.
   localparam int TIMEOUT_MULT = 40;
   localparam int TIMEOUT_W    = 20;

   typedef enum logic [1:0] {
      s_OFF   = 2'd0,
      s_RUN   = 2'd1,
      s_FLUSH = 2'd2
   } rx_state_t;

   // A divisor below 2 cannot produce a usable bit period.
   function automatic logic [13:0] baud_sanitize(input logic [13:0] i_val);
      return (i_val < 14'd2) ? 14'd2 : i_val;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous byte FIFO for received characters.
// A push while full is accepted only when a pop happens in the same cycle,
// so a full FIFO can stream without losing data. Flush clears the pointers.
module rx_fifo
   import usrt_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Push,
   input  logic          i_Pop,
   input  logic          i_Flush,
   input  logic [7:0]    i_Data,
   output logic [7:0]    o_Data,
   output logic          o_Full,
   output logic          o_Empty,
   output logic [AW:0]   o_Level
);

   logic [7:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_level == (AW+1)'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_do_push = i_Push & (~w_full | i_Pop);
   assign w_do_pop  = i_Pop & ~w_empty;

   assign o_Data  = r_mem[r_rd_ptr];
   assign o_Full  = w_full;
   assign o_Empty = w_empty;
   assign o_Level = r_level;

   // Storage array: written on accepted pushes, never reset.
   always_ff @(posedge i_Clk) begin
      if (w_do_push && !i_Flush) begin
         r_mem[r_wr_ptr] <= i_Data;
      end
   end

   // Pointer and level bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge i_Clk) begin
      if (i_Reset || i_Flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/usrt_rx_ctrl.sv
// usrt_rx_ctrl: receive-side controller for the USRT receiver.
// APB register slave (CTRL/BAUD/STATUS/DATA), receive FIFO capture,
// overrun tracking and a registered level interrupt.
// Optional feature macro: USRT_RX_TIMEOUT_EN adds the idle timeout
// (STATUS.TIMEOUT, CTRL.IE_TO); without it those bits read 0.
//
// state   | meaning
// s_OFF   | receiver disabled, Done pulses discarded
// s_RUN   | receiver enabled, Done pulses pushed into the FIFO
// s_FLUSH | one cycle: FIFO and TIMEOUT cleared, receiver held off
module usrt_rx_ctrl
   import usrt_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [13:0] BAUD_RESET = 14'd434
) (
   input  logic        i_Pclk,
   input  logic        i_Reset,
   input  logic        i_Psel,
   input  logic        i_Penable,
   input  logic        i_Pwrite,
   input  logic [3:0]  i_Paddr,
   input  logic [15:0] i_Pwdata,
   output logic [15:0] o_Prdata,
   output logic        o_Pready,
   output logic [13:0] o_Baud,
   output logic        o_Enable,
   input  logic [7:0]  i_Rx_Data,
   input  logic        i_Rx_Done,
   output logic        o_Irq
);

   localparam int AW = $clog2(FIFO_DEPTH);

   rx_state_t   r_state;
   logic        r_enable;
   logic        r_en;
   logic        r_ie_rxne;
   logic        r_ie_ovr;
   logic [13:0] r_baud;
   logic        r_ovr;
   logic        r_irq;

   logic        w_access;
   logic        w_wr;
   logic        w_rd;
   logic [1:0]  w_sel;
   logic        w_wr_ctrl;
   logic        w_wr_baud;
   logic        w_wr_status;
   logic        w_rd_data;
   logic        w_flush_req;
   logic        w_en_nxt;
   logic        w_push;
   logic        w_pop;
   logic        w_fifo_flush;
   logic [7:0]  w_fifo_dout;
   logic        w_full;
   logic        w_empty;
   logic [AW:0] w_level;
   logic        w_rxne;
   logic        w_ovr_set;
   logic        w_timeout;
   logic        w_ie_to;
   logic [15:0] w_rdata;
   logic        w_unused_ok;

   assign w_access    = i_Psel & i_Penable;
   assign w_wr        = w_access & i_Pwrite;
   assign w_rd        = w_access & ~i_Pwrite;
   assign w_sel       = i_Paddr[3:2];
   assign w_wr_ctrl   = w_wr & (w_sel == REG_CTRL);
   assign w_wr_baud   = w_wr & (w_sel == REG_BAUD);
   assign w_wr_status = w_wr & (w_sel == REG_STATUS);
   assign w_rd_data   = w_rd & (w_sel == REG_DATA);
   assign w_flush_req = w_wr_ctrl & i_Pwdata[CTRL_FLUSH];
   // EN as it will be after this cycle, so a write and the state decision agree.
   assign w_en_nxt    = w_wr_ctrl ? i_Pwdata[CTRL_EN] : r_en;

   assign w_fifo_flush = (r_state == s_FLUSH);
   assign w_push       = i_Rx_Done & (r_state == s_RUN);
   assign w_pop        = w_rd_data & ~w_empty & ~w_fifo_flush;
   assign w_rxne       = ~w_empty;
   // Same-cycle pop makes room, so only an unmatched push into a full FIFO overruns.
   assign w_ovr_set    = w_push & w_full & ~w_pop;

   assign w_unused_ok = &{1'b0, i_Paddr[1:0], i_Pwdata[15:14]};

   rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .i_Clk   (i_Pclk),
      .i_Reset (i_Reset),
      .i_Push  (w_push),
      .i_Pop   (w_pop),
      .i_Flush (w_fifo_flush),
      .i_Data  (i_Rx_Data),
      .o_Data  (w_fifo_dout),
      .o_Full  (w_full),
      .o_Empty (w_empty),
      .o_Level (w_level)
   );

   // Receiver state machine with registered enable to the shift register.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_state  <= s_OFF;
         r_enable <= 1'b0;
      end else begin
         case (r_state)
            s_OFF: begin
               if (w_flush_req) begin
                  r_state  <= s_FLUSH;
                  r_enable <= 1'b0;
               end else if (w_en_nxt) begin
                  r_state  <= s_RUN;
                  r_enable <= 1'b1;
               end
            end
            s_RUN: begin
               if (w_flush_req) begin
                  r_state  <= s_FLUSH;
                  r_enable <= 1'b0;
               end else if (!w_en_nxt) begin
                  r_state  <= s_OFF;
                  r_enable <= 1'b0;
               end
            end
            s_FLUSH: begin
               if (w_flush_req) begin
                  r_state  <= s_FLUSH;
                  r_enable <= 1'b0;
               end else if (w_en_nxt) begin
                  r_state  <= s_RUN;
                  r_enable <= 1'b1;
               end else begin
                  r_state  <= s_OFF;
                  r_enable <= 1'b0;
               end
            end
            default: begin
               r_state  <= s_OFF;
               r_enable <= 1'b0;
            end
         endcase
      end
   end

   // CTRL register bits (FLUSH is a strobe and is not stored).
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_en      <= 1'b0;
         r_ie_rxne <= 1'b0;
         r_ie_ovr  <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en      <= i_Pwdata[CTRL_EN];
         r_ie_rxne <= i_Pwdata[CTRL_IE_RXNE];
         r_ie_ovr  <= i_Pwdata[CTRL_IE_OVR];
      end
   end

   // Baud divisor, frozen while the receiver is enabled.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_baud <= BAUD_RESET;
      end else if (w_wr_baud && !r_en) begin
         r_baud <= baud_sanitize(i_Pwdata[13:0]);
      end
   end

   // Overrun flag: a new overrun beats a simultaneous W1C.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_ovr <= 1'b0;
      end else if (w_ovr_set) begin
         r_ovr <= 1'b1;
      end else if (w_wr_status && i_Pwdata[ST_OVR]) begin
         r_ovr <= 1'b0;
      end
   end

`ifdef USRT_RX_TIMEOUT_EN
   logic                 r_ie_to;
   logic                 r_timeout;
   logic [TIMEOUT_W-1:0] r_idle_cnt;
   logic [TIMEOUT_W-1:0] w_idle_limit;
   logic                 w_idle_reload;

   assign w_idle_limit  = TIMEOUT_W'(r_baud) * TIMEOUT_W'(TIMEOUT_MULT);
   assign w_idle_reload = w_fifo_flush | w_push | w_pop | w_empty;
   assign w_timeout     = r_timeout;
   assign w_ie_to       = r_ie_to;

   // Timeout interrupt enable bit of CTRL.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_ie_to <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_ie_to <= i_Pwdata[CTRL_IE_TO];
      end
   end

   // Idle down-counter: reloaded by FIFO activity or emptiness, holds at zero.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_idle_reload) begin
            r_idle_cnt <= w_idle_limit;
         end else if (r_idle_cnt != '0) begin
            r_idle_cnt <= r_idle_cnt - TIMEOUT_W'(1);
         end
         if (w_fifo_flush) begin
            r_timeout <= 1'b0;
         end else if (!w_idle_reload && (r_idle_cnt == '0)) begin
            r_timeout <= 1'b1;
         end else if (w_wr_status && i_Pwdata[ST_TO]) begin
            r_timeout <= 1'b0;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_ie_to   = 1'b0;
`endif

   // Registered level interrupt.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (w_rxne & r_ie_rxne) | (r_ovr & r_ie_ovr) | (w_timeout & w_ie_to);
      end
   end

   // APB read mux; DATA returns the FIFO head directly, 0 when empty.
   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (w_sel)
            REG_CTRL: begin
               w_rdata[CTRL_EN]      = r_en;
               w_rdata[CTRL_IE_RXNE] = r_ie_rxne;
               w_rdata[CTRL_IE_OVR]  = r_ie_ovr;
               w_rdata[CTRL_IE_TO]   = w_ie_to;
            end
            REG_BAUD: begin
               w_rdata[13:0] = r_baud;
            end
            REG_STATUS: begin
               w_rdata[ST_RXNE] = w_rxne;
               w_rdata[ST_FULL] = w_full;
               w_rdata[ST_OVR]  = r_ovr;
               w_rdata[ST_TO]   = w_timeout;
               w_rdata[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(w_level);
            end
            REG_DATA: begin
               w_rdata[7:0] = w_empty ? 8'h00 : w_fifo_dout;
            end
            default: w_rdata = '0;
         endcase
      end
   end

   assign o_Prdata = w_rdata;
   assign o_Pready = 1'b1;
   assign o_Baud   = r_baud;
   assign o_Enable = r_enable;
   assign o_Irq    = r_irq;

endmodule

// File: doc/usrt_rx_ctrl.md
# usrt_rx_ctrl

Receive-side controller for the USRT serial receiver. It owns the baud divisor and enable that drive the Rx shift register, and captures each completed byte (`i_Rx_Done` pulse) into a receive FIFO. It reports status, overrun and interrupts, and exposes everything to the CPU through an APB-style register slave on the peripheral clock. It sits between the APB interconnect and the Rx shift register.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, 2..16.
- `BAUD_RESET`, 14'd434: reset value of the BAUD register.

Ports:
- `i_Pclk` input 1: peripheral clock; the only clock.
- `i_Reset` input 1: synchronous, active-high reset.
- `i_Psel`, `i_Penable`, `i_Pwrite` input 1: APB control.
- `i_Paddr` input 4: byte address; `[3:2]` selects the register.
- `i_Pwdata` input 16: APB write data.
- `o_Prdata` output 16: APB read data; valid in the access phase.
- `o_Pready` output 1: tied to 1 (zero wait states).
- `o_Baud` output 14: divisor to the shift register.
- `o_Enable` output 1: receiver enable to the shift register.
- `i_Rx_Data` input 8: byte from the shift register.
- `i_Rx_Done` input 1: one-cycle pulse; `i_Rx_Data` is valid in the same cycle.
- `o_Irq` output 1: level interrupt, registered.

## Operation
Registers:
- 0x0 CTRL
  - [0] EN
  - [1] IE_RXNE
  - [2] IE_OVR
  - [3] IE_TO
  - [4] FLUSH: write-1 only; reads as 0.
- 0x4 BAUD [13:0]
  - Writes are ignored while EN=1.
  - Writes of 0 or 1 are stored as 2.
- 0x8 STATUS
  - [0] RXNE
  - [1] FULL
  - [2] OVR (W1C)
  - [3] TIMEOUT (W1C)
  - [12:8] LEVEL
- 0xC DATA [7:0]
  - A read pops the FIFO head.
  - A read when empty returns 0 and does not pop.
  - Writes are ignored.

Access rules:
- Reads and writes take effect in the cycle where `i_Psel & i_Penable` is high.
- Unused bits read 0.

State machine (2-bit):
- s_OFF: `o_Enable`=0.
  - CTRL.EN written 1 → s_RUN.
- s_RUN: `o_Enable`=1; `i_Rx_Done` pushes `i_Rx_Data`.
  - EN written 0 → s_OFF.
  - FLUSH written 1 → s_FLUSH.
- s_FLUSH: FIFO pointers and TIMEOUT cleared; `o_Enable`=0 for this one cycle.
  - Returns to s_RUN if EN=1, otherwise to s_OFF.
  - FLUSH written in s_OFF also enters s_FLUSH.

Input gating and disable:
- `i_Rx_Done` is discarded in s_OFF and s_FLUSH.
- A frame in flight when EN drops completes inside the shift register; its Done is discarded.

FIFO boundaries:
- Push when full with no pop in the same cycle: byte dropped, OVR set, FIFO unchanged.
- Push and pop in the same cycle: both performed; no OVR even when full; LEVEL unchanged.
- Push and pop when empty: the pop returns 0; the push is stored.
- Pointers wrap modulo `FIFO_DEPTH`.
- LEVEL is 0..`FIFO_DEPTH`.

Status update ordering:
- A W1C write to OVR in the same cycle as a new overrun: OVR stays 1 (set wins).

Interrupt:
- `o_Irq` <= (RXNE&IE_RXNE) | (OVR&IE_OVR) | (TIMEOUT&IE_TO).

Reset values:
- CTRL 0; BAUD `BAUD_RESET`; FIFO empty; OVR and TIMEOUT 0; state s_OFF.
- `o_Enable` 0, `o_Irq` 0, `o_Prdata` 0, `o_Baud` `BAUD_RESET`.

## Timing
- `o_Baud` and `o_Enable` are registered and change the cycle after the APB access.
- `i_Rx_Done` at cycle t: the data is visible at DATA, and RXNE reads 1, from cycle t+1.
- `o_Irq` asserts at t+2.
- DATA read at cycle t: `o_Prdata` is combinational from the FIFO head in cycle t; the pop is committed at the t+1 edge.
- A reset asserted mid-frame or mid-access returns all state to reset values at the next edge.

## Configuration
- `USRT_RX_TIMEOUT_EN` defined:
  - A 20-bit idle counter runs while RXNE=1.
  - It clears on every push, every pop, and whenever the FIFO is empty.
  - When it reaches 40×BAUD (four 10-bit character times), TIMEOUT is set and the counter holds.
- `USRT_RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - STATUS[3] and CTRL[3] read 0.
  - TIMEOUT never contributes to `o_Irq`.

## Structure
- Shared package `usrt_pkg`:
  - register offsets;
  - CTRL/STATUS bit positions;
  - state encodings (s_OFF, s_RUN, s_FLUSH);
  - timeout multiplier constant 40.
- Sub-module `rx_fifo`:
  - synchronous FIFO with push, pop, flush, data out, full, empty and level;
  - simultaneous push/pop when full is supported;
  - instantiated once.

## Test plan
- Reset, then read BAUD, CTRL, STATUS → 434, 0, 0; `o_Enable`=0.
- Write BAUD=100, then CTRL=0x3; pulse Done with 0xA5 → `o_Irq`=1 two cycles later; DATA reads 0xA5; RXNE=0; `o_Irq` drops.
- With EN=1, push 9 bytes (depth 8) → LEVEL=8, FULL=1, OVR=1, the 9th byte is lost; writing STATUS with 0x4 clears OVR.
- FIFO full, DATA read in the same cycle as a Done pulse → no OVR, LEVEL stays 8, oldest byte returned.
- Write BAUD=50 while EN=1 → BAUD still 100; Done pulse with EN=0 → FIFO still empty; FLUSH with 3 entries → LEVEL=0.
- With the macro defined: BAUD=10, one byte pushed, idle 400 cycles → TIMEOUT=1 and `o_Irq` with IE_TO set; with the macro undefined, STATUS[3] stays 0.
